// File: rtl/pic_exec_core.sv
// rtl/pic_exec_core.sv - PIC-style execute stage: decode, operand-B mux, 8-bit ALU, STATUS flags (optional STATUS_DC_EN digit carry)
module pic_exec_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       inst_reg,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic             d,
    output logic [3:0]       inst,
    output logic [2:0]       bit_number,
    output logic             switch_a_m,
    output logic             carry,
    output logic             zero
`ifdef STATUS_DC_EN
    ,
    output logic             dc
`endif
);

    typedef enum logic [3:0] {
        OP_PASSB = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_IOR   = 4'd4,
        OP_XOR   = 4'd5,
        OP_COM   = 4'd6,
        OP_INC   = 4'd7,
        OP_DEC   = 4'd8,
        OP_RLF   = 4'd9,
        OP_RRF   = 4'd10,
        OP_SWAP  = 4'd11,
        OP_BCF   = 4'd12,
        OP_BSF   = 4'd13,
        OP_CLR   = 4'd14,
        OP_PASSA = 4'd15
    } alu_op_t;

    logic [1:0]       cls;
    logic [3:0]       op4;
    logic [1:0]       bitop;
    logic             dbit;
    logic             unused_inst_lsb;
    alu_op_t          op;
    logic             d_dec;
    logic [WIDTH:0]   res9;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mask;
    logic             c_en;
    logic             c_next;
    logic             z_en;

    assign cls             = inst_reg[7:6];
    assign op4             = inst_reg[5:2];
    assign dbit            = inst_reg[1];
    assign bitop           = inst_reg[5:4];
    assign bit_number      = inst_reg[3:1];
    assign unused_inst_lsb = inst_reg[0];

    always_comb begin
        op         = OP_PASSA;
        d_dec      = 1'b0;
        switch_a_m = 1'b0;
        case (cls)
            2'b00: begin
                d_dec = dbit;
                case (op4)
                    4'b0000: op = OP_PASSA;
                    4'b0001: op = OP_CLR;
                    4'b0010: op = OP_SUB;
                    4'b0011: op = OP_DEC;
                    4'b0100: op = OP_IOR;
                    4'b0101: op = OP_AND;
                    4'b0110: op = OP_XOR;
                    4'b0111: op = OP_ADD;
                    4'b1000: op = OP_PASSB;
                    4'b1001: op = OP_COM;
                    4'b1010: op = OP_INC;
                    4'b1011: op = OP_DEC;
                    4'b1100: op = OP_RRF;
                    4'b1101: op = OP_RLF;
                    4'b1110: op = OP_SWAP;
                    default: op = OP_INC;
                endcase
            end
            2'b01: begin
                d_dec = 1'b1;
                case (bitop)
                    2'b00:   op = OP_BCF;
                    2'b01:   op = OP_BSF;
                    default: op = OP_PASSB;
                endcase
            end
            2'b10: op = OP_PASSA;
            default: begin
                switch_a_m = 1'b1;
                casez (op4)
                    4'b1000: op = OP_IOR;
                    4'b1001: op = OP_AND;
                    4'b1010: op = OP_XOR;
                    4'b110?: op = OP_SUB;
                    4'b111?: op = OP_ADD;
                    default: op = OP_PASSB;
                endcase
            end
        endcase
    end

    assign inst = op;
    assign b    = switch_a_m ? k : f;
    assign mask = WIDTH'(1) << bit_number;

    always_comb begin
        res9   = '0;
        c_en   = 1'b0;
        c_next = carry;
        z_en   = 1'b0;
        case (op)
            OP_PASSB: begin res9 = {1'b0, b};              z_en = (cls == 2'b00); end
            OP_ADD:   begin res9 = {1'b0, w} + {1'b0, b};  z_en = 1'b1; c_en = 1'b1; c_next = res9[WIDTH]; end
            // A borrow out of the 9-bit subtract means b < a, so C is its inverse.
            OP_SUB:   begin res9 = {1'b0, b} - {1'b0, w};  z_en = 1'b1; c_en = 1'b1; c_next = ~res9[WIDTH]; end
            OP_AND:   begin res9 = {1'b0, w & b};          z_en = 1'b1; end
            OP_IOR:   begin res9 = {1'b0, w | b};          z_en = 1'b1; end
            OP_XOR:   begin res9 = {1'b0, w ^ b};          z_en = 1'b1; end
            OP_COM:   begin res9 = {1'b0, ~b};             z_en = 1'b1; end
            OP_INC:   begin res9 = {1'b0, b} + 1'b1;       z_en = 1'b1; end
            OP_DEC:   begin res9 = {1'b0, b} - 1'b1;       z_en = 1'b1; end
            OP_RLF:   begin res9 = {1'b0, b[WIDTH-2:0], carry}; c_en = 1'b1; c_next = b[WIDTH-1]; end
            OP_RRF:   begin res9 = {1'b0, carry, b[WIDTH-1:1]}; c_en = 1'b1; c_next = b[0]; end
            OP_SWAP:  res9 = {1'b0, b[3:0], b[7:4]};
            OP_BCF:   res9 = {1'b0, b & ~mask};
            OP_BSF:   res9 = {1'b0, b | mask};
            OP_CLR:   begin res9 = '0;                     z_en = 1'b1; end
            default:  res9 = {1'b0, w};
        endcase
    end

    assign alu_res = res9[WIDTH-1:0];
    assign ans     = reset ? '0 : alu_res;
    assign d       = reset ? 1'b0 : d_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (c_en) carry <= c_next;
            if (z_en) zero  <= (alu_res == '0);
        end
    end

`ifdef STATUS_DC_EN
    logic [4:0] nib_sum;
    assign nib_sum = {1'b0, w[3:0]} + {1'b0, b[3:0]};

    always_ff @(posedge clk) begin
        if (reset)
            dc <= 1'b0;
        else if (op == OP_ADD)
            dc <= nib_sum[4];
        else if (op == OP_SUB)
            dc <= (b[3:0] >= w[3:0]);
    end
`endif

endmodule

// File: tb/tb_pic_exec_core.sv
// tb/tb_pic_exec_core.sv - directed and randomized checks of pic_exec_core against a behavioural model
module tb_pic_exec_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] inst_reg, k, f, w;
    logic [7:0] b, ans;
    logic       d;
    logic [3:0] inst;
    logic [2:0] bit_number;
    logic       switch_a_m, carry, zero;
`ifdef STATUS_DC_EN
    logic       dc;
`endif

    int checks = 0;
    int errors = 0;

    pic_exec_core #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .inst_reg(inst_reg), .k(k), .f(f), .w(w),
        .b(b), .ans(ans), .d(d), .inst(inst), .bit_number(bit_number),
        .switch_a_m(switch_a_m), .carry(carry), .zero(zero)
`ifdef STATUS_DC_EN
        , .dc(dc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ans;
        logic [7:0] b;
        logic       d;
        logic [3:0] op;
        logic       sam;
        logic       c;
        logic       z;
        logic       dc;
    } exp_t;

    logic mc = 1'b0, mz = 1'b0, mdc = 1'b0;
    exp_t ex;

    function automatic exp_t model(input logic [7:0] ir, input logic [7:0] kk, input logic [7:0] ff,
                                   input logic [7:0] ww, input logic c_in, input logic z_in,
                                   input logic dc_in, input logic rst);
        exp_t e;
        int cls, o4, A, B, r, bn;
        bit zaff;
        cls = int'(ir[7:6]); o4 = int'(ir[5:2]); bn = int'(ir[3:1]);
        e.sam = (cls == 3);
        e.d   = (cls == 0) ? ir[1] : (cls == 1);
        case (cls)
            0: begin
                int map[16] = '{15, 14, 2, 8, 4, 3, 5, 1, 0, 6, 7, 8, 10, 9, 11, 7};
                e.op = 4'(map[o4]);
            end
            1: e.op = (ir[5:4] == 0) ? 4'd12 : (ir[5:4] == 1) ? 4'd13 : 4'd0;
            2: e.op = 4'd15;
            default: e.op = (o4 < 8) ? 4'd0 : (o4 == 8) ? 4'd4 : (o4 == 9) ? 4'd3 :
                            (o4 == 10) ? 4'd5 : (o4 >= 14) ? 4'd1 : (o4 >= 12) ? 4'd2 : 4'd0;
        endcase
        A = int'(ww);
        B = e.sam ? int'(kk) : int'(ff);
        e.b = 8'(B);
        e.c = c_in; e.z = z_in; e.dc = dc_in;
        zaff = 1'b1;
        case (e.op)
            0:  begin r = B; zaff = (cls == 0); end
            1:  begin r = A + B; e.c = (r > 255); e.dc = ((A % 16) + (B % 16)) > 15; end
            2:  begin r = B - A + 256; e.c = (B >= A); e.dc = (B % 16) >= (A % 16); end
            3:  r = A & B;
            4:  r = A | B;
            5:  r = A ^ B;
            6:  r = 255 - B;
            7:  r = B + 1;
            8:  r = B + 255;
            9:  begin r = B * 2 + int'(c_in); e.c = (B >= 128); zaff = 1'b0; end
            10: begin r = B / 2 + 128 * int'(c_in); e.c = (B % 2 == 1); zaff = 1'b0; end
            11: begin r = (B % 16) * 16 + B / 16; zaff = 1'b0; end
            12: begin r = B & ~(1 << bn); zaff = 1'b0; end
            13: begin r = B | (1 << bn); zaff = 1'b0; end
            14: r = 0;
            default: begin r = A; zaff = 1'b0; end
        endcase
        r = r % 256;
        if (zaff) e.z = (r == 0);
        e.ans = 8'(r);
        if (rst) begin
            e.ans = 8'h00; e.d = 1'b0; e.c = 1'b0; e.z = 1'b0; e.dc = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ir, input logic [7:0] kk, input logic [7:0] ff,
                         input logic [7:0] ww, input logic rst);
        @(negedge clk);
        inst_reg = ir; k = kk; f = ff; w = ww; reset = rst;
        ex = model(ir, kk, ff, ww, mc, mz, mdc, rst);
        #1;
        chk("b", b, ex.b);
        chk("ans", ans, ex.ans);
        chk("d", {7'd0, d}, {7'd0, ex.d});
        chk("inst", {4'd0, inst}, {4'd0, ex.op});
        chk("bit_number", {5'd0, bit_number}, {5'd0, ir[3:1]});
        chk("switch_a_m", {7'd0, switch_a_m}, {7'd0, ex.sam});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mc = ex.c; mz = ex.z; mdc = ex.dc;
        chk("carry", {7'd0, carry}, {7'd0, mc});
        chk("zero", {7'd0, zero}, {7'd0, mz});
`ifdef STATUS_DC_EN
        chk("dc", {7'd0, dc}, {7'd0, mdc});
`endif
    endtask

    initial begin
        logic [7:0] ir;
        reset = 1'b1; inst_reg = 8'h00; k = 8'h00; f = 8'h00; w = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_carry", {7'd0, carry}, 8'd0);
        chk("reset_zero", {7'd0, zero}, 8'd0);
        chk("reset_ans", ans, 8'h00);

        drive(8'h1C, 8'h00, 8'd10, 8'd25, 1'b0);
        chk("addwf_ans", ans, 8'd35);
        chk("addwf_inst", {4'd0, inst}, 8'd1);
        tick();
        chk("addwf_c", {7'd0, carry}, 8'd0);

        drive(8'h0A, 8'h00, 8'd10, 8'd10, 1'b0);
        chk("subwf_ans", ans, 8'd0);
        chk("subwf_d", {7'd0, d}, 8'd1);
        tick();
        chk("subwf_z", {7'd0, zero}, 8'd1);
        chk("subwf_c", {7'd0, carry}, 8'd1);
        drive(8'h0A, 8'h00, 8'd1, 8'd10, 1'b0);
        chk("subwf_neg_ans", ans, 8'd247);
        tick();
        chk("subwf_neg_c", {7'd0, carry}, 8'd0);

        drive(8'hFB, 8'hF0, 8'h00, 8'h20, 1'b0);
        chk("addlw_ans", ans, 8'h10);
        chk("addlw_b", b, 8'hF0);
        tick();
        chk("addlw_c", {7'd0, carry}, 8'd1);

        drive(8'h56, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("bsf_ans", ans, 8'h08);
        chk("bsf_inst", {4'd0, inst}, 8'd13);
        tick();

        drive(8'h36, 8'h00, 8'h80, 8'h00, 1'b0);
        chk("rlf_ans", ans, 8'h01);
        tick();
        chk("rlf_c", {7'd0, carry}, 8'd1);

        drive(8'h1C, 8'h00, 8'h01, 8'hFF, 1'b0);
        tick();
        chk("pre_reset_z", {7'd0, zero}, 8'd1);
        drive(8'h1C, 8'h00, 8'h01, 8'hFF, 1'b1);
        chk("in_reset_ans", ans, 8'h00);
        chk("in_reset_d", {7'd0, d}, 8'd0);
        tick();
        chk("post_reset_c", {7'd0, carry}, 8'd0);
        drive(8'h1C, 8'h00, 8'h01, 8'hFF, 1'b0);
        chk("wrap_add_ans", ans, 8'h00);
        tick();
        chk("wrap_add_c", {7'd0, carry}, 8'd1);
        chk("wrap_add_z", {7'd0, zero}, 8'd1);

        drive(8'h28, 8'h00, 8'hFF, 8'h00, 1'b0);
        chk("incf_wrap", ans, 8'h00);
        tick();
        drive(8'h0C, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("decf_wrap", ans, 8'hFF);
        tick();

        for (int i = 0; i < 400; i++) begin
            ir = 8'($urandom);
            if (ir[7:6] == 2'b11 && ir[5:2] == 4'b1011) ir[2] = 1'b0;
            drive(ir, 8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(19) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
